spi_reg_bank: RTL and testbench

Byte-level command decoder and 16×8 register bank that sits directly downstream of `SPI_slave`. It consumes the received-byte strobe and data, and the frame-select indication. It interprets each chip-select frame as one command byte followed by data bytes with auto-incrementing addresses. It supplies the byte `SPI_slave` shifts out on MISO, and drives the board LED and debug state outputs.

---
 rtl/spi_reg_bank.sv | 147 ++++++++++++++
 tb/tb_spi_reg_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// Command decoder and register bank behind an SPI byte slave: one command byte per
// chip-select frame, then data bytes written or read at auto-incrementing addresses.
module spi_reg_bank #(
    parameter int         NREGS    = 16,
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       frame_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       led,
    output logic [2:0] state,
    output logic [7:0] frame_count
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_addr_inc;
    logic [AW-1:0]   w_cmd_addr;
    logic [7:0]      r_tx;
    logic [7:0]      r_fcount;
    logic            r_armed;
    logic            r_data_seen;
    logic            w_byte_ok;
    logic            w_wr_en;
    logic            w_cmd_rsvd;
    logic [7:0]      w_regs [NREGS];

    assign w_byte_ok  = rx_valid && frame_active;
    assign w_wr_en    = w_byte_ok && (r_state == S_WRITE);
    assign w_cmd_rsvd = (rx_data[6:4] != 3'b000);
    assign w_cmd_addr = rx_data[AW-1:0];
    assign w_addr_inc = r_addr + AW'(1);

    // The last register is a read-only ID; all others are writable flops.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == NREGS - 1) begin : g_id
                assign w_regs[gi] = ID_VALUE;
            end else begin : g_rw
                logic [7:0] r_val;
                always_ff @(posedge clk_25m or negedge rst_n) begin
                    if (!rst_n) begin
                        r_val <= 8'h00;
                    end else if (w_wr_en && (r_addr == AW'(gi))) begin
                        r_val <= rx_data;
                    end
                end
                assign w_regs[gi] = r_val;
            end
        end
    endgenerate

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_armed blocks a frame already in progress at reset release from being decoded.
    always_comb begin
        w_state_next = r_state;
        if (!frame_active) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_armed) w_state_next = S_CMD;
                end
                S_CMD: begin
                    if (w_byte_ok) begin
                        if (w_cmd_rsvd)      w_state_next = S_ERROR;
                        else if (rx_data[7]) w_state_next = S_WRITE;
                        else                 w_state_next = S_READ;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_tx        <= 8'h00;
            r_fcount    <= 8'h00;
            r_armed     <= 1'b0;
            r_data_seen <= 1'b0;
        end else if (!frame_active) begin
            r_armed     <= 1'b1;
            r_tx        <= 8'h00;
            r_data_seen <= 1'b0;
            if ((r_state == S_WRITE || r_state == S_READ) && r_data_seen) begin
                r_fcount <= r_fcount + 8'd1;
            end
        end else begin
            case (r_state)
                S_IDLE: r_tx <= 8'h00;
                S_CMD: begin
                    if (w_byte_ok) begin
                        r_addr      <= w_cmd_addr;
                        r_data_seen <= 1'b0;
                        if (w_cmd_rsvd)      r_tx <= ERR_BYTE;
                        else if (rx_data[7]) r_tx <= rx_data;
                        else                 r_tx <= w_regs[w_cmd_addr];
                    end
                end
                S_WRITE: begin
                    if (w_byte_ok) begin
                        r_addr      <= w_addr_inc;
                        r_tx        <= rx_data;
                        r_data_seen <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_byte_ok) begin
                        r_addr      <= w_addr_inc;
                        r_tx        <= w_regs[w_addr_inc];
                        r_data_seen <= 1'b1;
                    end
                end
                default: r_tx <= ERR_BYTE;
            endcase
        end
    end

    assign tx_data     = r_tx;
    assign led         = w_regs[0][0];
    assign state       = r_state;
    assign frame_count = r_fcount;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frame table, hand-built reset/abort sequences,
// then random frames against a frame-level register-bank model.
module tb_spi_reg_bank;
    logic       clk_25m;
    logic       rst_n;
    logic       frame_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       led;
    logic [2:0] state;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    spi_reg_bank dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .frame_active(frame_active),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .led         (led),
        .state       (state),
        .frame_count (frame_count)
    );

    initial clk_25m = 1'b0;
    always #20 clk_25m = ~clk_25m;

    typedef struct packed {
        logic [2:0]  n;
        logic [31:0] bytes;
        logic [31:0] txs;
        logic [2:0]  st;
        logic        led;
        logic [7:0]  fc;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] m_regs [16];
    logic [7:0] m_fc;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else begin
            $display("ok   %s: %02h", name, act);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_25m);
    endtask

    // Returns at the sampling point one clock edge after the byte strobe.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_25m);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk_25m);
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk_25m);
        frame_active = 1'b1;
        @(negedge clk_25m);
        check("start_state", {5'b0, state}, 8'd1);
        check("start_tx", tx_data, 8'h00);
        idle(2);
    endtask

    task automatic end_frame(input logic [7:0] exp_fc);
        @(negedge clk_25m);
        frame_active = 1'b0;
        @(negedge clk_25m);
        check("end_state", {5'b0, state}, 8'd0);
        check("end_tx", tx_data, 8'h00);
        check("end_fcount", frame_count, exp_fc);
        idle(1);
    endtask

    task automatic add_vec(input int n, input logic [31:0] bytes, input logic [31:0] txs,
                           input logic [2:0] st, input logic ld, input logic [7:0] fc);
        vec_t v;
        v.n     = 3'(n);
        v.bytes = bytes;
        v.txs   = txs;
        v.st    = st;
        v.led   = ld;
        v.fc    = fc;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] m_read(input int a);
        return m_regs[a % 16];
    endfunction

    initial begin
        rst_n        = 1'b0;
        frame_active = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;

        // Reset values
        idle(3);
        check("rst_tx", tx_data, 8'h00);
        check("rst_state", {5'b0, state}, 8'd0);
        check("rst_led", {7'b0, led}, 8'd0);
        check("rst_fcount", frame_count, 8'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed frames; state carries from one entry to the next
        add_vec(2, 32'h80010000, 32'h80010000, 3'd2, 1'b1, 8'd1);
        add_vec(3, 32'h82112200, 32'h82112200, 3'd2, 1'b1, 8'd2);
        add_vec(3, 32'h02000000, 32'h11220000, 3'd3, 1'b1, 8'd3);
        add_vec(4, 32'h8E334455, 32'h8E334455, 3'd2, 1'b1, 8'd4);
        add_vec(2, 32'h0F000000, 32'hA5550000, 3'd3, 1'b1, 8'd5);
        add_vec(3, 32'h0E000000, 32'h33A55500, 3'd3, 1'b1, 8'd6);
        add_vec(2, 32'h40120000, 32'hEEEE0000, 3'd4, 1'b1, 8'd6);
        add_vec(1, 32'h81000000, 32'h81000000, 3'd2, 1'b1, 8'd6);
        add_vec(2, 32'h00000000, 32'h55000000, 3'd3, 1'b1, 8'd7);
        add_vec(2, 32'h80020000, 32'h80020000, 3'd2, 1'b0, 8'd8);

        for (int k = 0; k < vecs.size(); k++) begin
            start_frame();
            for (int i = 0; i < int'(vecs[k].n); i++) begin
                send_byte(vecs[k].bytes[31-8*i -: 8]);
                check($sformatf("vec%0d_tx%0d", k, i), tx_data, vecs[k].txs[31-8*i -: 8]);
                check($sformatf("vec%0d_st%0d", k, i), {5'b0, state}, {5'b0, vecs[k].st});
                idle(2);
            end
            check($sformatf("vec%0d_led", k), {7'b0, led}, {7'b0, vecs[k].led});
            end_frame(vecs[k].fc);
        end

        // Reset mid-frame: partial frame must not be decoded after release
        start_frame();
        send_byte(8'h80);
        check("mr_state_wr", {5'b0, state}, 8'd2);
        idle(1);
        @(negedge clk_25m);
        rst_n = 1'b0;
        #5;
        check("mr_async_state", {5'b0, state}, 8'd0);
        check("mr_async_fcount", frame_count, 8'd0);
        @(negedge clk_25m);
        rst_n = 1'b1;
        idle(2);
        check("mr_hold_state", {5'b0, state}, 8'd0);
        send_byte(8'h77);
        check("mr_ign_state", {5'b0, state}, 8'd0);
        check("mr_ign_tx", tx_data, 8'h00);
        check("mr_ign_led", {7'b0, led}, 8'd0);
        idle(2);
        end_frame(8'd0);
        start_frame();
        send_byte(8'h00);
        check("mr_rd0", tx_data, 8'h00);
        idle(2);
        send_byte(8'h00);
        check("mr_rd1", tx_data, 8'h00);
        idle(2);
        end_frame(8'd1);

        // frame_active falls in the same cycle as a byte: byte dropped, frame still counted
        start_frame();
        send_byte(8'h81);
        check("ff_cmd_tx", tx_data, 8'h81);
        idle(2);
        send_byte(8'hAB);
        check("ff_d0_tx", tx_data, 8'hAB);
        idle(2);
        @(negedge clk_25m);
        rx_valid     = 1'b1;
        rx_data      = 8'hCD;
        frame_active = 1'b0;
        @(negedge clk_25m);
        rx_valid = 1'b0;
        check("ff_state", {5'b0, state}, 8'd0);
        check("ff_tx", tx_data, 8'h00);
        check("ff_fcount", frame_count, 8'd2);
        idle(2);
        start_frame();
        send_byte(8'h01);
        check("ff_rd_r1", tx_data, 8'hAB);
        idle(2);
        send_byte(8'h00);
        check("ff_rd_r2", tx_data, 8'h00);
        idle(2);
        end_frame(8'd3);

        // Random frames against the model, starting from reset
        @(negedge clk_25m);
        rst_n = 1'b0;
        @(negedge clk_25m);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) m_regs[a] = 8'h00;
        m_regs[15] = 8'hA5;
        m_fc = 8'd0;
        idle(2);

        for (int f = 0; f < 60; f++) begin
            int n;
            int start;
            int kind;   // 0 write, 1 read, 2 error
            logic [7:0] cmd;
            logic [7:0] b;
            logic [7:0] exp_tx;
            logic [2:0] exp_st;

            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk_25m);
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                @(negedge clk_25m);
                rx_valid = 1'b0;
                check("rnd_gap_state", {5'b0, state}, 8'd0);
                check("rnd_gap_tx", tx_data, 8'h00);
            end

            n = $urandom_range(1, 6);
            if ($urandom_range(0, 5) == 0) cmd = 8'($urandom);
            else                           cmd = {1'($urandom), 3'b000, 4'($urandom)};
            start = int'(cmd[3:0]);
            if (cmd[6:4] != 3'b000) kind = 2;
            else if (cmd[7])        kind = 0;
            else                    kind = 1;

            start_frame();
            for (int i = 0; i < n; i++) begin
                b = (i == 0) ? cmd : 8'($urandom);
                send_byte(b);
                if (kind == 2) begin
                    exp_tx = 8'hEE;
                    exp_st = 3'd4;
                end else if (kind == 0) begin
                    exp_st = 3'd2;
                    exp_tx = b;
                    if (i > 0 && ((start + i - 1) % 16) != 15) m_regs[(start + i - 1) % 16] = b;
                end else begin
                    exp_st = 3'd3;
                    exp_tx = m_read(start + i);
                end
                check($sformatf("rnd%0d_tx%0d", f, i), tx_data, exp_tx);
                check($sformatf("rnd%0d_st%0d", f, i), {5'b0, state}, {5'b0, exp_st});
                check($sformatf("rnd%0d_led%0d", f, i), {7'b0, led}, {7'b0, m_regs[0][0]});
                idle(2);
            end
            if (kind != 2 && n > 1) m_fc = m_fc + 8'd1;
            end_frame(m_fc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
